// File: rtl/byte_stripe_pkg.sv
// Shared constants for the transmit-side byte striper: lane select encoding,
// valid hold length and the idle-counter width helper.
package byte_stripe_pkg;

    localparam int DEF_DATA_W = 32;

    localparam logic [0:0] LANE0 = 1'b0;
    localparam logic [0:0] LANE1 = 1'b1;

    // Each captured word is presented for this many cycles on its lane.
    localparam int VALID_HOLD = 2;

    // Counter width able to hold 0..n, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/stripe_lane_reg.sv
// One output lane of the striper: data register, valid hold counter and,
// when STRIPE_PARITY_EN is defined, an even-parity bit registered with the data.
module stripe_lane_reg
    import byte_stripe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cap,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] lane,
`ifdef STRIPE_PARITY_EN
    output logic              parity,
`endif
    output logic              valid
);

    logic hold;

    // A capture (re)starts the hold; valid drops once the hold has drained.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane  <= '0;
            valid <= 1'b0;
            hold  <= 1'b0;
        end else if (cap) begin
            lane  <= data_in;
            valid <= 1'b1;
            hold  <= 1'(VALID_HOLD - 1);
        end else if (hold != 1'b0) begin
            hold  <= hold - 1'b1;
        end else begin
            valid <= 1'b0;
        end
    end

`ifdef STRIPE_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            parity <= 1'b0;
        else if (cap)
            parity <= ^data_in;
    end
`endif

endmodule

// File: rtl/byte_striping.sv
// Deals a full-rate word stream alternately onto two half-rate lanes.
// Optional per-lane parity outputs are enabled with `define STRIPE_PARITY_EN.
module byte_striping
    import byte_stripe_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int IDLE_RESET = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic [DATA_W-1:0] lane_0,
    output logic [DATA_W-1:0] lane_1,
    output logic              valid_0,
`ifdef STRIPE_PARITY_EN
    output logic              parity_0,
    output logic              parity_1,
`endif
    output logic              valid_1
);

    localparam int              CW       = cnt_w(IDLE_RESET);
    localparam logic [CW-1:0]   IDLE_MAX = CW'(IDLE_RESET);

    logic [0:0]    sel;
    logic [CW-1:0] idle_cnt;
    logic [CW-1:0] idle_nxt;
    logic          realign;
    logic          cap_0;
    logic          cap_1;

    assign cap_0 = valid_in && (sel == LANE0);
    assign cap_1 = valid_in && (sel == LANE1);

    // Realign fires on the edge where the idle run reaches IDLE_RESET.
    always_comb begin
        idle_nxt = idle_cnt;
        realign  = 1'b0;
        if (valid_in) begin
            idle_nxt = '0;
        end else if (IDLE_RESET != 0) begin
            if (idle_cnt != IDLE_MAX)
                idle_nxt = idle_cnt + 1'b1;
            realign = (idle_nxt == IDLE_MAX);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel      <= LANE0;
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_nxt;
            if (valid_in)
                sel <= (sel == LANE0) ? LANE1 : LANE0;
            else if (realign)
                sel <= LANE0;
        end
    end

    stripe_lane_reg #(.DATA_W(DATA_W)) u_lane_0 (
        .clk     (clk),
        .reset   (reset),
        .cap     (cap_0),
        .data_in (data_in),
        .lane    (lane_0),
`ifdef STRIPE_PARITY_EN
        .parity  (parity_0),
`endif
        .valid   (valid_0)
    );

    stripe_lane_reg #(.DATA_W(DATA_W)) u_lane_1 (
        .clk     (clk),
        .reset   (reset),
        .cap     (cap_1),
        .data_in (data_in),
        .lane    (lane_1),
`ifdef STRIPE_PARITY_EN
        .parity  (parity_1),
`endif
        .valid   (valid_1)
    );

endmodule

// File: tb/tb_byte_striping.sv
// Directed bench for byte_striping: reset, burst, gaps, idle realign and
// asynchronous reset, with hand-computed lane/valid expectations.
module tb_byte_striping;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_in;
    logic        valid_in;
    logic [31:0] lane_0;
    logic [31:0] lane_1;
    logic        valid_0;
    logic        valid_1;
`ifdef STRIPE_PARITY_EN
    logic        parity_0;
    logic        parity_1;
`endif

    int checks = 0;
    int fails  = 0;

    byte_striping #(.DATA_W(32), .IDLE_RESET(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .valid_in (valid_in),
        .lane_0   (lane_0),
        .lane_1   (lane_1),
        .valid_0  (valid_0),
`ifdef STRIPE_PARITY_EN
        .parity_0 (parity_0),
        .parity_1 (parity_1),
`endif
        .valid_1  (valid_1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] d, input logic v);
        data_in  = d;
        valid_in = v;
        tick();
    endtask

    task automatic chk1(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] l0, input logic v0,
                       input logic [31:0] l1, input logic v1);
        chk1({tag, ".lane_0"},  lane_0,  l0);
        chk1({tag, ".valid_0"}, {31'b0, valid_0}, {31'b0, v0});
        chk1({tag, ".lane_1"},  lane_1,  l1);
        chk1({tag, ".valid_1"}, {31'b0, valid_1}, {31'b0, v1});
`ifdef STRIPE_PARITY_EN
        chk1({tag, ".parity_0"}, {31'b0, parity_0}, {31'b0, ^l0});
        chk1({tag, ".parity_1"}, {31'b0, parity_1}, {31'b0, ^l1});
`endif
    endtask

    initial begin
        reset    = 1'b0;
        data_in  = 32'h1234_5678;
        valid_in = 1'b1;
        tick();
        tick();
        chk("reset", 32'h0, 1'b0, 32'h0, 1'b0);

        // Continuous burst; first word after release lands on lane_0.
        reset = 1'b1;
        drive(32'hFFFF_FFFF, 1'b1); chk("burst1", 32'hFFFF_FFFF, 1'b1, 32'h0,         1'b0);
        drive(32'hEEEE_EEEE, 1'b1); chk("burst2", 32'hFFFF_FFFF, 1'b1, 32'hEEEE_EEEE, 1'b1);
        drive(32'hDDDD_DDDD, 1'b1); chk("burst3", 32'hDDDD_DDDD, 1'b1, 32'hEEEE_EEEE, 1'b1);
        drive(32'hCCCC_CCCC, 1'b1); chk("burst4", 32'hDDDD_DDDD, 1'b1, 32'hCCCC_CCCC, 1'b1);
        drive(32'h0, 1'b0);         chk("burst5", 32'hDDDD_DDDD, 1'b0, 32'hCCCC_CCCC, 1'b1);
        drive(32'h0, 1'b0);         chk("burst6", 32'hDDDD_DDDD, 1'b0, 32'hCCCC_CCCC, 1'b0);

        // Pair, two idle cycles, pair.
        drive(32'h0000_0003, 1'b1); chk("gap1", 32'h0000_0003, 1'b1, 32'hCCCC_CCCC, 1'b0);
        drive(32'h0000_0004, 1'b1); chk("gap2", 32'h0000_0003, 1'b1, 32'h0000_0004, 1'b1);
        drive(32'h0, 1'b0);         chk("gap3", 32'h0000_0003, 1'b0, 32'h0000_0004, 1'b1);
        drive(32'h0, 1'b0);         chk("gap4", 32'h0000_0003, 1'b0, 32'h0000_0004, 1'b0);
        drive(32'hAAAA_AAAA, 1'b1); chk("gap5", 32'hAAAA_AAAA, 1'b1, 32'h0000_0004, 1'b0);
        drive(32'h9999_9999, 1'b1); chk("gap6", 32'hAAAA_AAAA, 1'b1, 32'h9999_9999, 1'b1);
        drive(32'h0, 1'b0);
        drive(32'h0, 1'b0);         chk("gap7", 32'hAAAA_AAAA, 1'b0, 32'h9999_9999, 1'b0);

        // Odd burst, two idle cycles realign to lane_0.
        drive(32'h1111_1111, 1'b1); chk("realign1", 32'h1111_1111, 1'b1, 32'h9999_9999, 1'b0);
        drive(32'h0, 1'b0);         chk("realign2", 32'h1111_1111, 1'b1, 32'h9999_9999, 1'b0);
        drive(32'h0, 1'b0);         chk("realign3", 32'h1111_1111, 1'b0, 32'h9999_9999, 1'b0);
        drive(32'h2222_2222, 1'b1); chk("realign4", 32'h2222_2222, 1'b1, 32'h9999_9999, 1'b0);
        drive(32'h0, 1'b0);         chk("realign5", 32'h2222_2222, 1'b1, 32'h9999_9999, 1'b0);
        drive(32'h0, 1'b0);         chk("realign6", 32'h2222_2222, 1'b0, 32'h9999_9999, 1'b0);

        // Odd burst, single idle cycle: no realign.
        drive(32'h1111_1111, 1'b1); chk("short1", 32'h1111_1111, 1'b1, 32'h9999_9999, 1'b0);
        drive(32'h0, 1'b0);         chk("short2", 32'h1111_1111, 1'b1, 32'h9999_9999, 1'b0);
        drive(32'h2222_2222, 1'b1); chk("short3", 32'h1111_1111, 1'b0, 32'h2222_2222, 1'b1);

        // Reset mid-burst clears outputs before the next edge.
        drive(32'h0000_0007, 1'b1); chk("midrst1", 32'h0000_0007, 1'b1, 32'h2222_2222, 1'b1);
        reset = 1'b0;
        #1;
        chk("midrst2", 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        reset = 1'b1;
        drive(32'h5555_5555, 1'b1); chk("midrst3", 32'h5555_5555, 1'b1, 32'h0, 1'b0);
        drive(32'h6666_6666, 1'b1); chk("midrst4", 32'h5555_5555, 1'b1, 32'h6666_6666, 1'b1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
